// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared defaults, width helper and parameter legality check for the prefetch buffer
package prefetch_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int DEPTH_DEF    = 4;
   localparam int AF_LEVEL_DEF = DEPTH_DEF - 1;
   localparam int AE_LEVEL_DEF = 1;

   function automatic int clog2_depth(input int depth);
      return $clog2(depth);
   endfunction

   function automatic bit params_ok(input int data_w, input int depth, input int af, input int ae);
      return data_w >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
             af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
   endfunction

endpackage

// File: rtl/prefetch_buffer_if.sv
// prefetch_buffer_if: producer/consumer handshakes plus status outputs of the prefetch buffer
interface prefetch_buffer_if
   import prefetch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
);
   localparam int CW = clog2_depth(DEPTH) + 1;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CW-1:0]     count;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     hwm;
   logic              overflow;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, almost_full, almost_empty, hwm, overflow
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, almost_full, almost_empty, hwm, overflow
   );

endinterface

// File: rtl/prefetch_ptr.sv
// prefetch_ptr: wrapping pointer register with increment and synchronous clear
module prefetch_ptr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_ptr
);

   logic [W-1:0] r_ptr;

   // clear wins over increment; the natural wrap handles DEPTH-1 -> 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_ptr <= '0;
      else if (i_clr) r_ptr <= '0;
      else if (i_inc) r_ptr <= r_ptr + 1'b1;
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: show-ahead queue with flush, watermarks, occupancy, high-water mark and sticky overflow
module prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = AE_LEVEL_DEF
) (
   input logic              clk,
   input logic              rst_n,
   prefetch_buffer_if.slave bus
);

   localparam int PW = clog2_depth(DEPTH);
   localparam int CW = PW + 1;

   if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
      $error("prefetch_buffer: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_hwm;
   logic              r_ovf;
   logic [PW-1:0]     w_head;
   logic [PW-1:0]     w_tail;
   logic              w_push;
   logic              w_pop;
   logic [CW-1:0]     w_count_nxt;

   // a full buffer still accepts when the consumer drains in the same cycle
   assign bus.in_ready     = (r_count != CW'(DEPTH)) | bus.out_ready;
   assign bus.out_valid    = (r_count != '0);
   assign bus.out_data     = r_mem[w_head];
   assign bus.count        = r_count;
   assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
   assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
   assign bus.hwm          = r_hwm;
   assign bus.overflow     = r_ovf;

   assign w_push      = bus.in_valid & bus.in_ready & ~bus.flush;
   assign w_pop       = bus.out_valid & bus.out_ready & ~bus.flush;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   prefetch_ptr #(.W(PW)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_pop),
      .i_clr (bus.flush),
      .o_ptr (w_head)
   );

   prefetch_ptr #(.W(PW)) u_tail (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_push),
      .i_clr (bus.flush),
      .o_ptr (w_tail)
   );

   // storage is deliberately unreset; out_data is only meaningful while out_valid
   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_tail] <= bus.in_data;
   end

   // occupancy, high-water mark and sticky overflow, all cleared by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_hwm   <= '0;
         r_ovf   <= 1'b0;
      end else if (bus.flush) begin
         r_count <= '0;
         r_hwm   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_hwm   <= (w_count_nxt > r_hwm) ? w_count_nxt : r_hwm;
         r_ovf   <= r_ovf | (bus.in_valid & ~bus.in_ready);
      end
   end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Parametrised show-ahead prefetch buffer. It holds up to DEPTH words of DATA_W bits between the fetch unit (producer) and the decode stage (consumer), using valid/ready handshakes on both sides. It adds the following on top of a basic queue:
- a single-cycle flush for branch redirects;
- almost-full and almost-empty watermarks;
- an occupancy count and a high-water mark;
- a sticky overflow flag.

## Interface
- DATA_W, 8, word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  discard all entries this cycle
- in_valid  in  1  producer offers in_data
- in_ready  out  1  buffer can accept; equals !full | out_ready
- in_data  in  DATA_W  write word
- out_valid  out  1  equals !empty
- out_ready  in  1  consumer takes out_data
- out_data  out  DATA_W  entry at head (show-ahead, combinational from storage)
- count  out  $clog2(DEPTH)+1  current occupancy
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- hwm  out  $clog2(DEPTH)+1  maximum count since reset or last flush
- overflow  out  1  sticky: in_valid was high while in_ready was low

## Operation
- Push: occurs when in_valid & in_ready & !flush. Writes mem[tail], then tail increments.
- Pop: occurs when out_valid & out_ready & !flush. Head increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update: count += push − pop. Simultaneous push and pop leaves count unchanged.
- Full with out_ready=1: in_ready=1, so push and pop occur together.
- Empty: push only. There is no bypass, so in_data never appears on out_data in the same cycle.
- flush has priority over push and pop. Next cycle: head=tail=0, count=0, hwm=0, overflow=0.
- Storage is not cleared by reset or flush. out_data is don't-care while out_valid=0.
- hwm update: hwm ← max(hwm, count_next) every cycle with no flush.
- overflow: set when in_valid & !in_ready & !flush; cleared only by reset or flush.
- A rejected write (in_ready=0) leaves all storage and pointers unchanged.

## Timing
- Reset (rst_n=0, asynchronous), effective immediately:
  - head, tail, count, hwm = 0; overflow = 0.
  - Outputs: in_ready=1, out_valid=0, almost_full=0, almost_empty=1 (for AE_LEVEL ≥ 0).
- Reset asserted mid-operation discards all contents. Deassertion is synchronous to clk at the bench level.
- Write-to-read latency is 1 cycle: a word pushed at edge k is on out_data with out_valid=1 after edge k.
- count, flags and hwm are registered or derived from registered count, so they change only after an edge.
- Combinational paths:
  - out_ready → in_ready.
  - head → out_data.
  - No other input-to-output paths.
- in_valid and in_data need not be held after a rejection. The producer is responsible for retrying.

## Structure
- Package prefetch_pkg holds:
  - the parameter defaults;
  - a function clog2_depth;
  - an elaboration-time parameter-legality check (DEPTH power of two, AF/AE ranges).
- Sub-module prefetch_ptr: a wrapping pointer register with increment and clear inputs. It is instantiated twice, for head and tail.
- Storage is an unreset register array in the top module.

## Test plan
All scenarios use DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
- Fill then drain:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44, then pop four times.
  - Required response:
    - out_data sequence 0x11, 0x22, 0x33, 0x44.
    - count 1,2,3,4 then 3,2,1,0.
    - almost_full rises at count=3; almost_empty asserted at count ≤1.
    - hwm=4.
- Full with simultaneous push and pop:
  - Stimulus: buffer full with 0xA0..0xA3; push 0xB0 with out_ready=1.
  - Required response: in_ready=1, count stays 4, next out_data=0xA1, 0xB0 emerges fourth.
- Overflow:
  - Stimulus: buffer full, out_ready=0, in_valid=1 with 0xCC for 2 cycles.
  - Required response:
    - in_ready=0; contents unchanged.
    - overflow=1 and stays 1 after draining.
    - A subsequent flush clears overflow.
- Flush priority:
  - Stimulus: count=2; same cycle assert flush, in_valid=1, out_ready=1.
  - Required response:
    - Next cycle count=0, out_valid=0, hwm=0.
    - The word pushed next is the first word out.
- Wrap-around:
  - Stimulus: 10 push/pop pairs of 0x00..0x09 keeping count ≤2.
  - Required response: in-order output and correct data across pointer wrap.
- Async reset mid-stream:
  - Stimulus: rst_n=0 between edges with count=3.
  - Required response:
    - out_valid=0, count=0, in_ready=1 before the next edge.
    - Normal operation resumes after release.
